// File: rtl/vedic_pkg.sv
// Shared widths, FSM encoding and the step->shift table for the sequential
// 8x8 multiplier built from four 4x4 vedic-core products.
package vedic_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int RES_W  = 16;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial product weight: lo*lo=0, hi*lo=4, lo*hi=4, hi*hi=8
  localparam logic [3:0] STEP_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    return STEP_SHIFT[step];
  endfunction

endpackage

// File: rtl/vedic_seq_mul8_dp.sv
// Datapath: latched operands, nibble select toward the 4x4 core and the
// shift/accumulate of core products into the 16-bit result.
module vedic_seq_mul8_dp
  import vedic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic              drive_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              acc_en_i,
  input  logic              fin_i,
  input  logic [OP_W-1:0]   core_p_i,
  output logic [NIB_W-1:0]  core_a_o,
  output logic [NIB_W-1:0]  core_b_o,
  output logic [RES_W-1:0]  product_o
);

  logic [OP_W-1:0]  op_a_q, op_b_q;
  logic [RES_W-1:0] acc_q, acc_d, partial, product_q;

  // step bit 0 selects the high nibble of op_a, bit 1 the high nibble of op_b
  always_comb begin
    core_a_o = '0;
    core_b_o = '0;
    if (drive_i) begin
      core_a_o = step_i[0] ? op_a_q[7:4] : op_a_q[3:0];
      core_b_o = step_i[1] ? op_b_q[7:4] : op_b_q[3:0];
    end
  end

  always_comb begin
    partial = RES_W'(core_p_i) << step_shift(step_i);
    acc_d   = acc_q + partial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      if (load_i) begin
        op_a_q <= a_i;
        op_b_q <= b_i;
        acc_q  <= '0;
      end else if (acc_en_i) begin
        acc_q <= acc_d;
      end
      if (fin_i) begin
        product_q <= acc_d;
      end
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/vedic_seq_mul8.sv
// Iterative 8x8 unsigned multiplier: sequences four nibble pairs through an
// external 4x4 core and hands the 16-bit product out on a valid/ready port.
module vedic_seq_mul8
  import vedic_pkg::*;
#(
  parameter int CORE_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [NIB_W-1:0]  core_a,
  output logic [NIB_W-1:0]  core_b,
  input  logic [OP_W-1:0]   core_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  product,
  output state_e            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, ready depends on state only.

  if (CORE_LAT != 0 && CORE_LAT != 1) begin : g_bad_core_lat
    $error("vedic_seq_mul8: CORE_LAT must be 0 or 1");
  end

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              phase_q, phase_d;
  logic              last_cycle, accept, drive, acc_en, fin;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    phase_d    = phase_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    drive      = 1'b0;
    acc_en     = 1'b0;
    fin        = 1'b0;
    // With a registered core, core_p is valid only in the second cycle of a step
    last_cycle = (CORE_LAT == 0) ? 1'b1 : phase_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = MUL;
          step_d  = '0;
          phase_d = 1'b0;
        end
      end
      MUL: begin
        drive   = 1'b1;
        phase_d = ~phase_q;
        if (last_cycle) begin
          acc_en  = 1'b1;
          phase_d = 1'b0;
          if (step_q == 2'd3) begin
            fin     = 1'b1;
            step_d  = '0;
            state_d = DONE;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  vedic_seq_mul8_dp u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .a_i      (a),
    .b_i      (b),
    .drive_i  (drive),
    .step_i   (step_q),
    .acc_en_i (acc_en),
    .fin_i    (fin),
    .core_p_i (core_p),
    .core_a_o (core_a),
    .core_b_o (core_b),
    .product_o(product)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_vedic_seq_mul8.sv
// Bench for vedic_seq_mul8: one instance per core latency, each with its own
// 4x4 core model, checked against a*b and the expected handshake timing.
module tb_vedic_seq_mul8;
  import vedic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  a_s       [2];
  logic [7:0]  b_s       [2];
  logic [3:0]  core_a    [2];
  logic [3:0]  core_b    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] product   [2];
  state_e      dbg_state [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cur_u    = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] core_p_g;

    vedic_seq_mul8 #(.CORE_LAT(g)) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a_s[g]),
      .b        (b_s[g]),
      .core_a   (core_a[g]),
      .core_b   (core_b[g]),
      .core_p   (core_p_g),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .product  (product[g]),
      .dbg_state(dbg_state[g])
    );

    if (g == 0) begin : g_comb_core
      assign core_p_g = {4'b0, core_a[g]} * {4'b0, core_b[g]};
    end else begin : g_reg_core
      always @(posedge clk) core_p_g <= {4'b0, core_a[g]} * {4'b0, core_b[g]};
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL [lat%0d] %s: got 0x%0h expected 0x%0h", cur_u, tag, got, exp);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    #2;
    for (int u = 0; u < 2; u++) begin
      if (!rst[u] && out_valid[u] && out_ready[u]) begin
        if (u == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0)
          check("scoreboard unexpected product", 32'(product[u]), 32'hFFFF_FFFF);
        else if (u == 0)
          check("scoreboard product", 32'(product[u]), 32'(exp_q0.pop_front()));
        else
          check("scoreboard product", 32'(product[u]), 32'(exp_q1.pop_front()));
      end
      if (!rst[u] && in_valid[u] && in_ready[u]) begin
        if (u == 0) exp_q0.push_back(ref_mul(a_s[u], b_s[u]));
        else        exp_q1.push_back(ref_mul(a_s[u], b_s[u]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int u);
    rst[u] = 1'b1; in_valid[u] = 1'b1; out_ready[u] = 1'b0;
    a_s[u] = 8'hAA; b_s[u] = 8'h55;
    tick(); tick();
    check("reset state", 32'(dbg_state[u]), 32'(IDLE));
    check("reset in_ready", 32'(in_ready[u]), 32'd1);
    check("reset out_valid", 32'(out_valid[u]), 32'd0);
    check("reset product", 32'(product[u]), 32'd0);
    check("reset core_a", 32'(core_a[u]), 32'd0);
    check("reset core_b", 32'(core_b[u]), 32'd0);
    rst[u] = 1'b0; in_valid[u] = 1'b0;
    tick();
    check("post-reset nothing accepted", 32'(in_ready[u]), 32'd1);
  endtask

  // Latency counts cycles from the accept cycle to the first out_valid cycle.
  task automatic run_op(input int u, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input logic ready, input int exp_lat);
    int lat;
    a_s[u] = av; b_s[u] = bv; in_valid[u] = 1'b1; out_ready[u] = ready;
    check("op in_ready", 32'(in_ready[u]), 32'd1);
    tick();
    in_valid[u] = 1'b0;
    a_s[u] = 8'($urandom_range(0, 255));
    b_s[u] = 8'($urandom_range(0, 255));
    lat = 1;
    while (!out_valid[u] && lat < 40) begin
      tick();
      lat++;
    end
    check($sformatf("latency %02h*%02h", av, bv), 32'(lat), 32'(exp_lat));
    check($sformatf("product %02h*%02h", av, bv), 32'(product[u]), 32'(exp));
    check("done core_a idle", 32'({core_a[u], core_b[u]}), 32'd0);
  endtask

  task automatic finish_op(input int u);
    out_ready[u] = 1'b1;
    tick();
    check("after transfer out_valid", 32'(out_valid[u]), 32'd0);
    check("after transfer in_ready", 32'(in_ready[u]), 32'd1);
  endtask

  task automatic backpressure(input int u, input int exp_lat);
    run_op(u, 8'h5A, 8'hC3, 16'h448E, 1'b0, exp_lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold out_valid", 32'(out_valid[u]), 32'd1);
      check("hold product", 32'(product[u]), 32'h448E);
      check("hold in_ready", 32'(in_ready[u]), 32'd0);
    end
    finish_op(u);
    tick();
    check("single transfer", 32'(out_valid[u]), 32'd0);
  endtask

  task automatic back_to_back(input int u, input int exp_gap);
    logic [7:0]  pat [2];
    int          acc_cyc [2];
    logic [15:0] got [$];
    int          n, cyc;
    logic        acc_now;
    pat[0] = 8'h0F; pat[1] = 8'hF0;
    n = 0; cyc = 0;
    out_ready[u] = 1'b1;
    a_s[u] = pat[0]; b_s[u] = pat[0]; in_valid[u] = 1'b1;
    while (cyc < 60 && got.size() < 2) begin
      acc_now = in_valid[u] && in_ready[u];
      if (out_valid[u] && out_ready[u]) got.push_back(product[u]);
      tick();
      cyc++;
      if (acc_now && n < 2) begin
        acc_cyc[n] = cyc;
        n++;
        if (n < 2) begin
          a_s[u] = pat[1]; b_s[u] = pat[1];
        end else begin
          in_valid[u] = 1'b0;
        end
      end
    end
    in_valid[u] = 1'b0;
    check("b2b accept count", 32'(n), 32'd2);
    if (n == 2) check("b2b accept gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(exp_gap));
    check("b2b product count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("b2b product 0F*0F", 32'(got[0]), 32'h00E1);
      check("b2b product F0*F0", 32'(got[1]), 32'hE100);
    end
  endtask

  task automatic reset_mid_op(input int u, input int exp_lat);
    a_s[u] = 8'h9C; b_s[u] = 8'h6B; in_valid[u] = 1'b1; out_ready[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    repeat (u == 0 ? 2 : 4) tick();
    check("step2 core_a", 32'(core_a[u]), 32'hC);
    check("step2 core_b", 32'(core_b[u]), 32'h6);
    rst[u] = 1'b1;
    tick();
    check("mid reset out_valid", 32'(out_valid[u]), 32'd0);
    check("mid reset in_ready", 32'(in_ready[u]), 32'd1);
    check("mid reset core_a", 32'(core_a[u]), 32'd0);
    check("mid reset core_b", 32'(core_b[u]), 32'd0);
    check("mid reset product", 32'(product[u]), 32'd0);
    rst[u] = 1'b0;
    if (u == 0) exp_q0.delete(); else exp_q1.delete();
    run_op(u, 8'h03, 8'h05, 16'h000F, 1'b1, exp_lat);
    finish_op(u);
  endtask

  task automatic random_ops(input int u, input int n_ops);
    int   sent, guard, qsz;
    logic acc_now;
    sent = 0; guard = 0;
    a_s[u] = 8'($urandom_range(0, 255));
    b_s[u] = 8'($urandom_range(0, 255));
    in_valid[u] = 1'b1;
    while (sent < n_ops && guard < 40000) begin
      out_ready[u] = ($urandom_range(0, 3) != 0);
      acc_now = in_valid[u] && in_ready[u];
      tick();
      guard++;
      if (acc_now) begin
        sent++;
        a_s[u] = 8'($urandom_range(0, 255));
        b_s[u] = 8'($urandom_range(0, 255));
        in_valid[u] = ($urandom_range(0, 3) != 0);
      end else if (!in_valid[u]) begin
        in_valid[u] = 1'b1;
      end
    end
    check("random ops sent", 32'(sent), 32'(n_ops));
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b1;
    qsz = 1;
    for (int i = 0; i < 50 && qsz != 0; i++) begin
      tick();
      qsz = (u == 0) ? exp_q0.size() : exp_q1.size();
    end
    check("random drain", 32'(qsz), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; in_valid[u] = 1'b0; out_ready[u] = 1'b0;
      a_s[u] = 8'h00; b_s[u] = 8'h00;
    end
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      int lat, gap;
      cur_u = u;
      lat = (u == 0) ? 5 : 9;
      gap = (u == 0) ? 6 : 10;
      do_reset(u);
      run_op(u, 8'h12, 8'h34, 16'h03A8, 1'b1, lat); finish_op(u);
      run_op(u, 8'hFF, 8'hFF, 16'hFE01, 1'b1, lat); finish_op(u);
      run_op(u, 8'h00, 8'hA7, 16'h0000, 1'b1, lat); finish_op(u);
      run_op(u, 8'h10, 8'h01, 16'h0010, 1'b1, lat); finish_op(u);
      backpressure(u, lat);
      back_to_back(u, gap);
      reset_mid_op(u, lat);
      random_ops(u, 1000);
      rst[u] = 1'b1;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
